// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N decoder with one-hot, thermometer, autonomous scan and hold modes.
// All outputs are flops; SEL never reaches O combinationally.
module decoder_nx2n_seq #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [1:0]     mode,
    input  logic [N-1:0]   sel,
    input  logic           in_valid,
    output logic [2**N-1:0] o,
    output logic           out_valid,
    output logic           scan_wrap
);

    localparam int W  = 2**N;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

    scan_state_t     state;
    logic [N-1:0]    idx;
    logic [DW-1:0]   dwell;

    logic [W-1:0]    sel_onehot;
    logic [W-1:0]    sel_therm;
    logic [N-1:0]    idx_next;
    logic [W-1:0]    idx_next_onehot;

    // NOTE: every signal driven here is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        sel_onehot      = {{(W-1){1'b0}}, 1'b1} << sel;
        // Shifting twice keeps SEL = 2^N-1 from wrapping the shift amount; yields all ones.
        sel_therm       = ~(({W{1'b1}} << sel) << 1);
        idx_next        = idx + 1'b1;
        idx_next_onehot = {{(W-1){1'b0}}, 1'b1} << idx_next;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o         <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
            idx       <= '0;
            dwell     <= '0;
            state     <= IDLE;
        end else if (!en) begin
            o         <= '0;
            out_valid <= 1'b0;
            scan_wrap <= 1'b0;
            idx       <= '0;
            dwell     <= '0;
            state     <= IDLE;
        end else begin
            case (mode_t'(mode))
                MODE_ONEHOT: begin
                    state     <= IDLE;
                    scan_wrap <= 1'b0;
                    out_valid <= in_valid;
                    if (in_valid)
                        o <= sel_onehot;
                end
                MODE_THERM: begin
                    state     <= IDLE;
                    scan_wrap <= 1'b0;
                    out_valid <= in_valid;
                    if (in_valid)
                        o <= sel_therm;
                end
                MODE_SCAN: begin
                    if (state == IDLE) begin
                        state     <= RUN;
                        idx       <= '0;
                        dwell     <= '0;
                        o         <= {{(W-1){1'b0}}, 1'b1};
                        out_valid <= 1'b1;
                        scan_wrap <= 1'b0;
                    end else if (dwell == DWELL_LAST) begin
                        dwell     <= '0;
                        idx       <= idx_next;
                        o         <= idx_next_onehot;
                        out_valid <= 1'b1;
                        scan_wrap <= (idx == IDX_LAST);
                    end else begin
                        dwell     <= dwell + 1'b1;
                        out_valid <= 1'b0;
                        scan_wrap <= 1'b0;
                    end
                end
                MODE_HOLD: begin
                    // RUN survives hold so a direct return to scan resumes instead of restarting.
                    out_valid <= 1'b0;
                    scan_wrap <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Self-checking bench for decoder_nx2n_seq: directed scenarios plus randomized traffic
// compared against a tick-count reference model of the decoder.
module tb_decoder_nx2n_seq;

    localparam int N     = 3;
    localparam int DWELL = 4;
    localparam int W     = 2**N;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [1:0]     mode;
    logic [N-1:0]   sel;
    logic           in_valid;
    logic [W-1:0]   o;
    logic           out_valid;
    logic           scan_wrap;

    decoder_nx2n_seq #(.N(N), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .o         (o),
        .out_valid (out_valid),
        .scan_wrap (scan_wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: the scan is described by how many edges it has been running.
    logic [W-1:0] m_o;
    logic         m_ov;
    logic         m_sw;
    bit           m_active;
    int           m_ticks;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_o      = '0;
        m_ov     = 1'b0;
        m_sw     = 1'b0;
        m_active = 1'b0;
        m_ticks  = 0;
    endtask

    task automatic model_edge(input logic e, input logic [1:0] m, input logic [N-1:0] s, input logic v);
        int k;
        if (!e) begin
            model_reset();
            return;
        end
        m_sw = 1'b0;
        case (m)
            2'b00: begin
                m_active = 1'b0;
                m_ov     = v;
                if (v) begin
                    m_o    = '0;
                    m_o[s] = 1'b1;
                end
            end
            2'b01: begin
                m_active = 1'b0;
                m_ov     = v;
                if (v)
                    m_o = W'((1 << (int'(s) + 1)) - 1);
            end
            2'b10: begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_ticks  = 0;
                    m_o      = W'(1);
                    m_ov     = 1'b1;
                end else begin
                    m_ticks++;
                    if (m_ticks % DWELL == 0) begin
                        k      = (m_ticks / DWELL) % W;
                        m_o    = '0;
                        m_o[k] = 1'b1;
                        m_ov   = 1'b1;
                        m_sw   = (k == 0);
                    end else begin
                        m_ov = 1'b0;
                    end
                end
            end
            default: m_ov = 1'b0;
        endcase
    endtask

    // Drives inputs while clk is low, applies one rising edge, checks just after it,
    // and returns at the following falling edge.
    task automatic step(input logic e, input logic [1:0] m, input logic [N-1:0] s, input logic v);
        en       = e;
        mode     = m;
        sel      = s;
        in_valid = v;
        @(posedge clk);
        model_edge(e, m, s, v);
        #1;
        cyc++;
        check($sformatf("o@%0d", cyc), o, m_o);
        check($sformatf("out_valid@%0d", cyc), out_valid, m_ov);
        check($sformatf("scan_wrap@%0d", cyc), scan_wrap, m_sw);
        @(negedge clk);
    endtask

    initial begin
        int first_cyc;
        int wrap_cyc;
        int pulses;
        int run_len;
        logic [1:0] rmode;

        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 2'b00;
        sel      = '0;
        in_valid = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check("reset_o", o, '0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_scan_wrap", scan_wrap, 1'b0);
        rst_n = 1'b1;

        // One-hot sweep, then drop IN_VALID
        for (int i = 0; i < W; i++)
            step(1'b1, 2'b00, N'(i), 1'b1);
        check("onehot_last", o, 8'h80);
        step(1'b1, 2'b00, 3'd2, 1'b0);
        check("onehot_hold", o, 8'h80);
        check("onehot_hold_valid", out_valid, 1'b0);

        // Thermometer
        step(1'b1, 2'b01, 3'd2, 1'b1);
        check("therm_2", o, 8'h07);
        step(1'b1, 2'b01, 3'd7, 1'b1);
        check("therm_7", o, 8'hFF);
        step(1'b1, 2'b01, 3'd0, 1'b1);
        check("therm_0", o, 8'h01);

        // Scan timing and wrap distance
        first_cyc = -1;
        wrap_cyc  = -1;
        pulses    = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 2'b10, N'($urandom), 1'($urandom));
            if (first_cyc < 0 && o == 8'h01 && out_valid)
                first_cyc = cyc;
            else if (first_cyc >= 0 && cyc - first_cyc <= DWELL * W && out_valid)
                pulses++;
            if (wrap_cyc < 0 && scan_wrap)
                wrap_cyc = cyc;
        end
        check("wrap_distance", 64'(wrap_cyc - first_cyc), 64'(DWELL * W));
        check("scan_pulse_count", 64'(pulses), 64'(W));

        // Hold then resume without restart
        step(1'b1, 2'b00, 3'd0, 1'b0);
        for (int i = 0; i < 14; i++)
            step(1'b1, 2'b10, 3'd0, 1'b0);
        check("scan_at_08", o, 8'h08);
        for (int i = 0; i < 10; i++)
            step(1'b1, 2'b11, N'($urandom), 1'b1);
        check("hold_08", o, 8'h08);
        step(1'b1, 2'b10, 3'd0, 1'b0);
        step(1'b1, 2'b10, 3'd0, 1'b0);
        check("resume_still_08", o, 8'h08);
        step(1'b1, 2'b10, 3'd0, 1'b0);
        check("resume_10", o, 8'h10);
        check("resume_10_valid", out_valid, 1'b1);

        // Asynchronous reset mid-scan
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'b10, 3'd0, 1'b0);
        check("scan_at_20", o, 8'h20);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_o", o, '0);
        check("async_reset_valid", out_valid, 1'b0);
        #1 rst_n = 1'b1;
        step(1'b1, 2'b10, 3'd0, 1'b0);
        check("restart_after_reset", o, 8'h01);

        // Enable priority during scan
        for (int i = 0; i < 6; i++)
            step(1'b1, 2'b10, 3'd0, 1'b0);
        step(1'b0, 2'b10, 3'd5, 1'b1);
        check("en_low_o", o, '0);
        step(1'b1, 2'b10, 3'd5, 1'b1);
        check("en_restart", o, 8'h01);

        // Randomized traffic with runs of one mode so scans can progress
        for (int r = 0; r < 60; r++) begin
            rmode   = 2'($urandom);
            run_len = $urandom_range(1, 12);
            for (int i = 0; i < run_len; i++)
                step(1'($urandom_range(0, 15) != 0), rmode, N'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder_nx2n_seq.md
Name: decoder_nx2n_seq

Overview:
- Parametrised, registered N-to-2^N decoder; next generation of the team's fixed 2-to-4 / 3-to-8 decoders.
- Adds a clocked output stage with a valid flag, a thermometer mode and an autonomous scan mode.
- Scan mode walks a one-hot output across all lines on its own timing.
- Sits between control logic and strobe/select fan-out: chip selects, LED/row scanning, mux selects.

Parameters:
- N, 3, select width; output width is 2^N.
- DWELL, 4, clock cycles each output stays active in scan mode (DWELL >= 1).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  block enable; low forces outputs to zero.
- MODE  input  2  00 = one-hot decode, 01 = thermometer decode, 10 = scan, 11 = hold.
- SEL  input  N  select code for modes 00/01.
- IN_VALID  input  1  SEL is valid this cycle (modes 00/01 only).
- O  output  2^N  registered decoder outputs; O[0] corresponds to SEL = 0.
- OUT_VALID  output  1  O holds a freshly updated pattern.
- SCAN_WRAP  output  1  one-cycle pulse when scan index wraps from 2^N-1 to 0.

Behaviour:
- Reset, asynchronous, RST_N low: O = 0, OUT_VALID = 0, SCAN_WRAP = 0, scan index = 0, dwell counter = 0.
- Release from reset takes effect on the first rising edge with RST_N high.
- EN low, all modes: on the next edge O = 0, OUT_VALID = 0, SCAN_WRAP = 0. Scan index and dwell counter reset to 0.
- Mode 00, one-hot:
  - Edge with EN & IN_VALID: O = 1 << SEL, OUT_VALID = 1. Latency is 1 cycle.
  - Edge without IN_VALID: O holds, OUT_VALID = 0.
- Mode 01, thermometer:
  - Edge with EN & IN_VALID: O[i] = 1 for all i <= SEL, else 0. OUT_VALID = 1.
  - SEL = 2^N-1 gives all ones.
  - Without IN_VALID: O holds, OUT_VALID = 0.
- Mode 10, scan: SEL and IN_VALID are ignored. State machine with states IDLE and RUN.
  - Entering RUN (from any other mode, or from EN low): index = 0, dwell = 0. O = 1 on that edge, OUT_VALID = 1 for that one cycle.
  - In RUN, dwell counts 0..DWELL-1. When dwell = DWELL-1 at an edge:
    - dwell returns to 0 and index increments (mod 2^N);
    - O = 1 << new index, OUT_VALID = 1 for one cycle.
    - If the index goes 2^N-1 -> 0, SCAN_WRAP = 1 for that cycle.
  - Otherwise O holds and OUT_VALID = 0.
  - DWELL = 1 advances the index every cycle.
- Mode 11, hold: O frozen, OUT_VALID = 0, SCAN_WRAP = 0, scan state frozen.
  - Returning to mode 10 directly from 11 resumes the scan at the frozen index/dwell; it does not restart.
  - Any other mode entering 10 restarts the scan at index 0.
- Simultaneous events:
  - EN low has priority over everything except reset.
  - A mode change is sampled on the same edge as SEL/IN_VALID; the new mode governs that edge.
- Reset mid-scan: immediate clear of everything. After release with EN high and MODE = 10, the scan restarts at index 0 on the first edge.
- O is always a registered value; no combinational path from SEL to O.
- Widths: index is N bits and wraps naturally. Dwell counter is clog2(DWELL) bits, minimum 1.

Test Plan:
- Reset/idle: N = 3, assert RST_N low mid-operation with O = 8'h20 -> O = 0, OUT_VALID = 0 immediately, without waiting for a clock edge.
- One-hot sweep: EN = 1, MODE = 00, IN_VALID = 1, SEL = 0..7 on consecutive cycles -> O = 01, 02, 04 ... 80, each one cycle after SEL, with OUT_VALID = 1 each cycle. Drop IN_VALID -> O holds 80, OUT_VALID = 0.
- Thermometer: MODE = 01, SEL = 3'd2 -> O = 8'h07. SEL = 3'd7 -> O = 8'hFF. SEL = 0 -> O = 8'h01.
- Scan timing: MODE = 10, DWELL = 4 -> O = 01 for 4 cycles, then 02, ..., 80. The next step shows O = 01 with SCAN_WRAP = 1 exactly 32 cycles after the first 01. OUT_VALID pulses once every 4 cycles.
- Hold/resume: scan reaches O = 08, set MODE = 11 for 10 cycles -> O stays 08. Return to 10 -> the scan continues to 10 after the remaining dwell count, with no restart.
- Enable priority: during scan, drop EN with IN_VALID = 1 -> next edge O = 0. Re-raise EN in mode 10 -> scan restarts at O = 01.
